mult_bus_master: RTL and testbench
==================================

Name: mult_bus_master

Overview:
- Bus initiator that drives the multiplier/popcount GPIO emulator peripheral over its saddress/srd/swr/sdata strobe bus.
- Accepts an operand pair on a valid/ready request port and writes A1 then A2. It then writes the start register and polls status until ready.
- Reads back the 32-bit product W and the ones-count L, and returns them on a valid/ready response port.
- Sits host-side, in place of the software driver, for self-test and for offload of back-to-back operations.

Parameters:
- ADDR_A1, 16'h0380: first operand register address.
- ADDR_A2, 16'h0388: second operand register address.
- ADDR_W, 16'h0390: product (low 32 bits) read address.
- ADDR_L, 16'h0398: ones-count read address.
- ADDR_CTRL, 16'h03A0: start (write) / status B (read) address.
- STROBE_CYCLES, 2: clocks each srd/swr strobe is held high; minimum 1.
- POLL_LIMIT, 255: maximum status reads before timeout; minimum 1.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- n_reset, in, 1: asynchronous active-low reset.
- req_valid, in, 1: operand request valid.
- req_ready, out, 1: high only in IDLE.
- req_a1, in, 24: operand A1.
- req_a2, in, 24: operand A2.
- rsp_valid, out, 1: result valid; held until accepted.
- rsp_ready, in, 1: result accepted.
- rsp_w, out, 32: product read from ADDR_W.
- rsp_l, out, 24: ones count read from ADDR_L (bits 23:0 of read data).
- rsp_timeout, out, 1: status never showed ready within POLL_LIMIT reads.
- rsp_mismatch, out, 1: rsp_l differs from the locally computed popcount of rsp_w.
- saddress, out, 16: bus address.
- srd, out, 1: read strobe; the target acts on its rising edge.
- swr, out, 1: write strobe; the target acts on its rising edge.
- sdata_out, out, 32: write data, wired to the target's sdata_in.
- sdata_in, in, 32: read data, wired from the target's sdata_out.
- busy, out, 1: high whenever not in IDLE.

Behaviour:
- Reset (async, n_reset=0), applied immediately, including mid-transaction:
  - state=IDLE; srd=swr=0; saddress=0; sdata_out=0.
  - rsp_valid=0; rsp_w=0; rsp_l=0; rsp_timeout=0; rsp_mismatch=0.
  - poll counter=0; req_ready=1 once out of reset; busy=0.
- All outputs are registered.
- Bus access = 3 phases, 2+STROBE_CYCLES clocks total:
  - SETUP (1 clk): saddress and sdata_out driven, strobes low.
  - STROBE (STROBE_CYCLES clks): srd or swr high; address and data stable.
  - HOLD (1 clk): strobe low, address and data held.
  - Read data is captured from sdata_in at the clock edge that ends the last STROBE cycle.
- srd and swr are never high in the same cycle. Between accesses both strobes stay low ≥2 clks (HOLD + next SETUP).
- Outside accesses, saddress=0 and sdata_out=0.
- FSM, in order: IDLE -> WR_A1 -> WR_A2 -> WR_START -> POLL -> RD_W -> RD_L -> RESP -> IDLE.
  - IDLE: on req_valid&&req_ready, latch req_a1/req_a2, clear poll counter, go to WR_A1.
  - WR_A1: write {8'h0,a1} to ADDR_A1.
  - WR_A2: write {8'h0,a2} to ADDR_A2.
  - WR_START: write 32'h1 to ADDR_CTRL. This clears the target's status to 2'b01 and restarts its engine.
  - POLL: read ADDR_CTRL and increment the poll counter.
    - If captured bit[1]=1 (ready), go to RD_W.
    - Else if poll counter==POLL_LIMIT, set timeout, force rsp_w=0 and rsp_l=0, go to RESP.
    - Else issue another POLL access immediately.
  - RD_W: read ADDR_W into rsp_w.
  - RD_L: read ADDR_L; rsp_l = captured[23:0].
  - RESP:
    - rsp_valid=1; rsp_mismatch = (rsp_l != popcount(rsp_w)), forced 0 on timeout.
    - On rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE. rsp_w, rsp_l and the flags hold until the next RESP.
- Latency, STROBE_CYCLES=2, one poll: 6 accesses x 4 clks. If the request is accepted at edge k, rsp_valid is high after edge k+24. Each extra poll adds 2+STROBE_CYCLES clks.
- Request inputs are sampled only on acceptance; changes while busy are ignored.
- If rsp_ready is already high when rsp_valid rises, the result is accepted in that first RESP cycle and req_ready returns the next cycle.
- popcount: combinational sum of the 32 bits of rsp_w, 6-bit result, zero-extended to 24 bits for the compare.

Test Plan:
- Reset then A1=3, A2=5 against the peripheral model -> bus sequence:
  - writes 0x0380=3, 0x0388=5, 0x03A0;
  - ≥1 status read, then reads 0x0390 and 0x0398;
  - rsp_w=15, rsp_l=4, rsp_timeout=0, rsp_mismatch=0, rsp_valid after edge k+24 with a single poll.
- Bus protocol checker:
  - srd and swr never both high; each strobe high exactly STROBE_CYCLES clks;
  - saddress and sdata_out stable from SETUP through HOLD;
  - A1=24'hFFFFFF, A2=24'h000002 -> rsp_w=32'h01FFFFFE, rsp_l=24.
- Model holds status bit[1]=0 forever, POLL_LIMIT=4 -> exactly 4 reads of 0x03A0, no reads of 0x0390/0x0398, rsp_timeout=1, rsp_w=0, rsp_l=0.
- Model returns L=7 with W=15 -> rsp_mismatch=1, rsp_l=7.
- rsp_ready held low 10 clks -> rsp_valid and data stable, req_ready=0. A second request while busy is ignored until acceptance.
- n_reset pulsed low during the STROBE phase of WR_A2 -> swr, saddress and busy drop to 0 asynchronously. After release, a new request completes correctly.

Source files
------------

// File: rtl/mult_bus_master_if.sv
// Request/response handshake plus strobe-bus signals for the multiplier bus initiator.
// master = initiator view, slave = host and peripheral view.
interface mult_bus_master_if;
   logic        req_valid;
   logic        req_ready;
   logic [23:0] req_a1;
   logic [23:0] req_a2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_w;
   logic [23:0] rsp_l;
   logic        rsp_timeout;
   logic        rsp_mismatch;
   logic [15:0] saddress;
   logic        srd;
   logic        swr;
   logic [31:0] sdata_out;
   logic [31:0] sdata_in;
   logic        busy;

   modport master (
      input  req_valid, req_a1, req_a2, rsp_ready, sdata_in,
      output req_ready, rsp_valid, rsp_w, rsp_l, rsp_timeout, rsp_mismatch,
             saddress, srd, swr, sdata_out, busy
   );

   modport slave (
      output req_valid, req_a1, req_a2, rsp_ready, sdata_in,
      input  req_ready, rsp_valid, rsp_w, rsp_l, rsp_timeout, rsp_mismatch,
             saddress, srd, swr, sdata_out, busy
   );
endinterface

// File: rtl/mult_bus_master.sv
// Bus initiator for the multiplier/popcount peripheral: writes operands, starts,
// polls status, reads product and ones-count, returns them on a response port.
module mult_bus_master #(
   parameter logic [15:0] ADDR_A1       = 16'h0380,
   parameter logic [15:0] ADDR_A2       = 16'h0388,
   parameter logic [15:0] ADDR_W        = 16'h0390,
   parameter logic [15:0] ADDR_L        = 16'h0398,
   parameter logic [15:0] ADDR_CTRL     = 16'h03A0,
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned POLL_LIMIT    = 255
) (
   input  logic               clk,
   input  logic               n_reset,
   mult_bus_master_if.master  bus
);
   localparam int unsigned SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
   localparam int unsigned PCW = $clog2(POLL_LIMIT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_A1, S_WR_A2, S_WR_START, S_POLL, S_RD_W, S_RD_L, S_RESP
   } state_t;
   typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

   state_t           state_q, state_d;
   phase_t           phase_q, phase_d;
   logic [SCW-1:0]   scnt_q, scnt_d;
   logic [PCW-1:0]   pcnt_q, pcnt_d;
   logic [23:0]      a1_q, a1_d, a2_q, a2_d;
   logic [31:0]      rd_q, rd_d, w_q, w_d;
   logic [15:0]      saddress_q, saddress_d;
   logic [31:0]      sdata_out_q, sdata_out_d;
   logic             srd_q, srd_d, swr_q, swr_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_w_q, rsp_w_d;
   logic [23:0]      rsp_l_q, rsp_l_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             rsp_mismatch_q, rsp_mismatch_d;
   logic             req_ready_q, req_ready_d;
   logic             busy_q, busy_d;

   function automatic logic [5:0] popcount(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int unsigned i = 0; i < 32; i++) c = c + {5'b0, v[i]};
      return c;
   endfunction

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      scnt_d         = scnt_q;
      pcnt_d         = pcnt_q;
      a1_d           = a1_q;
      a2_d           = a2_q;
      rd_d           = rd_q;
      w_d            = w_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_w_d        = rsp_w_q;
      rsp_l_d        = rsp_l_q;
      rsp_timeout_d  = rsp_timeout_q;
      rsp_mismatch_d = rsp_mismatch_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               a1_d    = bus.req_a1;
               a2_d    = bus.req_a2;
               pcnt_d  = '0;
               state_d = S_WR_A1;
               phase_d = PH_SETUP;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            case (phase_q)
               PH_SETUP: begin
                  phase_d = PH_STROBE;
                  scnt_d  = '0;
               end
               PH_STROBE: begin
                  if (scnt_q == SCW'(STROBE_CYCLES - 1)) begin
                     phase_d = PH_HOLD;
                     if (state_q inside {S_POLL, S_RD_W, S_RD_L}) rd_d = bus.sdata_in;
                     if (state_q == S_POLL) pcnt_d = pcnt_q + 1'b1;
                  end else begin
                     scnt_d = scnt_q + 1'b1;
                  end
               end
               default: begin
                  // Next access (or response) is chosen at the end of HOLD so the
                  // following SETUP cycle already carries the new address.
                  phase_d = PH_SETUP;
                  case (state_q)
                     S_WR_A1:    state_d = S_WR_A2;
                     S_WR_A2:    state_d = S_WR_START;
                     S_WR_START: state_d = S_POLL;
                     S_POLL: begin
                        if (rd_q[1]) begin
                           state_d = S_RD_W;
                        end else if (pcnt_q == PCW'(POLL_LIMIT)) begin
                           state_d        = S_RESP;
                           rsp_valid_d    = 1'b1;
                           rsp_timeout_d  = 1'b1;
                           rsp_w_d        = '0;
                           rsp_l_d        = '0;
                           rsp_mismatch_d = 1'b0;
                        end
                     end
                     S_RD_W: begin
                        w_d     = rd_q;
                        state_d = S_RD_L;
                     end
                     S_RD_L: begin
                        state_d        = S_RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_timeout_d  = 1'b0;
                        rsp_w_d        = w_q;
                        rsp_l_d        = rd_q[23:0];
                        rsp_mismatch_d = (rd_q[23:0] != {18'b0, popcount(w_q)});
                     end
                     default: ;
                  endcase
               end
            endcase
         end
      endcase

      saddress_d  = '0;
      sdata_out_d = '0;
      case (state_d)
         S_WR_A1:    begin saddress_d = ADDR_A1;   sdata_out_d = {8'h0, a1_d}; end
         S_WR_A2:    begin saddress_d = ADDR_A2;   sdata_out_d = {8'h0, a2_d}; end
         S_WR_START: begin saddress_d = ADDR_CTRL; sdata_out_d = 32'h1;        end
         S_POLL:     saddress_d = ADDR_CTRL;
         S_RD_W:     saddress_d = ADDR_W;
         S_RD_L:     saddress_d = ADDR_L;
         default: ;
      endcase
      swr_d       = (phase_d == PH_STROBE) && (state_d inside {S_WR_A1, S_WR_A2, S_WR_START});
      srd_d       = (phase_d == PH_STROBE) && (state_d inside {S_POLL, S_RD_W, S_RD_L});
      req_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q        <= S_IDLE;
         phase_q        <= PH_SETUP;
         scnt_q         <= '0;
         pcnt_q         <= '0;
         a1_q           <= '0;
         a2_q           <= '0;
         rd_q           <= '0;
         w_q            <= '0;
         saddress_q     <= '0;
         sdata_out_q    <= '0;
         srd_q          <= 1'b0;
         swr_q          <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_w_q        <= '0;
         rsp_l_q        <= '0;
         rsp_timeout_q  <= 1'b0;
         rsp_mismatch_q <= 1'b0;
         req_ready_q    <= 1'b1;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         scnt_q         <= scnt_d;
         pcnt_q         <= pcnt_d;
         a1_q           <= a1_d;
         a2_q           <= a2_d;
         rd_q           <= rd_d;
         w_q            <= w_d;
         saddress_q     <= saddress_d;
         sdata_out_q    <= sdata_out_d;
         srd_q          <= srd_d;
         swr_q          <= swr_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_w_q        <= rsp_w_d;
         rsp_l_q        <= rsp_l_d;
         rsp_timeout_q  <= rsp_timeout_d;
         rsp_mismatch_q <= rsp_mismatch_d;
         req_ready_q    <= req_ready_d;
         busy_q         <= busy_d;
      end
   end

   assign bus.saddress     = saddress_q;
   assign bus.sdata_out    = sdata_out_q;
   assign bus.srd          = srd_q;
   assign bus.swr          = swr_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_w        = rsp_w_q;
   assign bus.rsp_l        = rsp_l_q;
   assign bus.rsp_timeout  = rsp_timeout_q;
   assign bus.rsp_mismatch = rsp_mismatch_q;
   assign bus.req_ready    = req_ready_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_mult_bus_master.sv
// Directed bench for mult_bus_master with a behavioural multiplier peripheral
// and a strobe-bus protocol monitor.
module tb_mult_bus_master;
   localparam int unsigned S  = 2;
   localparam int unsigned PL = 4;

   logic clk = 1'b0;
   logic n_reset;
   always #5 clk = ~clk;

   mult_bus_master_if bus();

   mult_bus_master #(.STROBE_CYCLES(S), .POLL_LIMIT(PL)) dut (
      .clk(clk), .n_reset(n_reset), .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Peripheral model
   int          cyc = 0;
   int          start_cyc = 0;
   int          ready_delay = 0;
   bit          never_ready = 1'b0;
   bit          l_override = 1'b0;
   logic [23:0] l_value = '0;
   logic [23:0] m_a1 = '0, m_a2 = '0;
   logic [47:0] m_p;
   logic [15:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [15:0] rd_addr_q[$];

   assign m_p = {24'b0, m_a1} * {24'b0, m_a2};

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge bus.swr) begin
      wr_addr_q.push_back(bus.saddress);
      wr_data_q.push_back(bus.sdata_out);
      case (bus.saddress)
         16'h0380: m_a1 <= bus.sdata_out[23:0];
         16'h0388: m_a2 <= bus.sdata_out[23:0];
         16'h03A0: start_cyc <= cyc;
         default: ;
      endcase
   end

   always @(posedge bus.srd) begin
      rd_addr_q.push_back(bus.saddress);
      case (bus.saddress)
         16'h03A0: bus.sdata_in <= {30'b0, (!never_ready && (cyc - start_cyc >= ready_delay)), 1'b1};
         16'h0390: bus.sdata_in <= m_p[31:0];
         16'h0398: bus.sdata_in <= l_override ? {8'b0, l_value} : {8'b0, 24'($countones(m_p[31:0]))};
         default:  bus.sdata_in <= '0;
      endcase
   end

   // Protocol monitor
   int          proto_err = 0;
   int          n_strobes = 0;
   int          slen = 0;
   bit          prev_strobe = 1'b0;
   logic [15:0] prev_addr = '0;
   logic [31:0] prev_data = '0;

   always @(negedge clk) begin
      if (!n_reset) begin
         slen = 0;
         prev_strobe = 1'b0;
      end else begin
         if (bus.srd && bus.swr) proto_err++;
         if ((bus.srd || bus.swr || prev_strobe) &&
             (bus.saddress !== prev_addr || bus.sdata_out !== prev_data)) proto_err++;
         if (bus.srd || bus.swr) begin
            slen++;
         end else begin
            if (prev_strobe) begin
               n_strobes++;
               if (slen != int'(S)) proto_err++;
            end
            slen = 0;
         end
         prev_strobe = bus.srd || bus.swr;
      end
      prev_addr = bus.saddress;
      prev_data = bus.sdata_out;
   end

   task automatic send(input logic [23:0] a1, input logic [23:0] a2);
      @(negedge clk);
      bus.req_a1    = a1;
      bus.req_a2    = a2;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 1000) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic accept();
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      bus.req_valid = 1'b0; bus.req_a1 = '0; bus.req_a2 = '0; bus.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if ({bus.srd, bus.swr, bus.busy, bus.rsp_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_in: srd/swr/busy/valid=%b want 0000", {bus.srd, bus.swr, bus.busy, bus.rsp_valid}); end
      @(negedge clk) n_reset = 1'b1;
      @(posedge clk); #1;
      n_tests++; if ({bus.req_ready, bus.busy} !== 2'b10) begin n_fail++; $display("FAIL reset_rdy: ready/busy=%b want 10", {bus.req_ready, bus.busy}); end
      n_tests++; if ({bus.saddress, bus.sdata_out} !== 48'h0) begin n_fail++; $display("FAIL reset_bus: addr=%h data=%h want 0", bus.saddress, bus.sdata_out); end
      n_tests++; if ({bus.rsp_w, bus.rsp_l, bus.rsp_timeout, bus.rsp_mismatch, bus.rsp_valid} !== 59'h0) begin n_fail++; $display("FAIL reset_rsp: w=%h l=%h to=%b mm=%b v=%b want 0", bus.rsp_w, bus.rsp_l, bus.rsp_timeout, bus.rsp_mismatch, bus.rsp_valid); end
   endtask

   task automatic test_basic();
      int lat, wb, rb;
      logic [47:0] exp_wr [3];
      logic [15:0] exp_rd [3];
      exp_wr[0] = {16'h0380, 32'd3}; exp_wr[1] = {16'h0388, 32'd5}; exp_wr[2] = {16'h03A0, 32'd1};
      exp_rd[0] = 16'h03A0; exp_rd[1] = 16'h0390; exp_rd[2] = 16'h0398;
      ready_delay = 0; never_ready = 1'b0; l_override = 1'b0;
      wb = wr_addr_q.size(); rb = rd_addr_q.size();
      send(24'd3, 24'd5);
      n_tests++; if ({bus.req_ready, bus.busy} !== 2'b01) begin n_fail++; $display("FAIL basic_busy: ready/busy=%b want 01", {bus.req_ready, bus.busy}); end
      wait_rsp(lat);
      n_tests++; if (lat != 24) begin n_fail++; $display("FAIL basic_latency: got %0d want 24", lat); end
      n_tests++; if (bus.rsp_w !== 32'd15) begin n_fail++; $display("FAIL basic_w: got %0d want 15", bus.rsp_w); end
      n_tests++; if (bus.rsp_l !== 24'd4) begin n_fail++; $display("FAIL basic_l: got %0d want 4", bus.rsp_l); end
      n_tests++; if ({bus.rsp_timeout, bus.rsp_mismatch} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: to/mm=%b want 00", {bus.rsp_timeout, bus.rsp_mismatch}); end
      n_tests++; if (wr_addr_q.size() - wb != 3 || rd_addr_q.size() - rb != 3) begin n_fail++; $display("FAIL basic_count: writes=%0d reads=%0d want 3 3", wr_addr_q.size() - wb, rd_addr_q.size() - rb); end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (wb + i >= wr_addr_q.size()) begin n_fail++; $display("FAIL basic_wr%0d: missing want %h", i, exp_wr[i]); end
         else if ({wr_addr_q[wb+i], wr_data_q[wb+i]} !== exp_wr[i]) begin n_fail++; $display("FAIL basic_wr%0d: got %h want %h", i, {wr_addr_q[wb+i], wr_data_q[wb+i]}, exp_wr[i]); end
         n_tests++;
         if (rb + i >= rd_addr_q.size()) begin n_fail++; $display("FAIL basic_rd%0d: missing want %h", i, exp_rd[i]); end
         else if (rd_addr_q[rb+i] !== exp_rd[i]) begin n_fail++; $display("FAIL basic_rd%0d: got %h want %h", i, rd_addr_q[rb+i], exp_rd[i]); end
      end
      accept();
      n_tests++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin n_fail++; $display("FAIL basic_accept: valid/ready=%b want 01", {bus.rsp_valid, bus.req_ready}); end
   endtask

   task automatic test_protocol();
      int lat, e0, s0, rb, nctrl;
      ready_delay = 6;
      e0 = proto_err; s0 = n_strobes; rb = rd_addr_q.size();
      send(24'hFFFFFF, 24'h000002);
      wait_rsp(lat);
      nctrl = 0;
      for (int i = rb; i < rd_addr_q.size(); i++) if (rd_addr_q[i] == 16'h03A0) nctrl++;
      n_tests++; if (lat != 28) begin n_fail++; $display("FAIL proto_latency: got %0d want 28", lat); end
      n_tests++; if (nctrl != 2) begin n_fail++; $display("FAIL proto_polls: got %0d want 2", nctrl); end
      n_tests++; if (bus.rsp_w !== 32'h01FFFFFE) begin n_fail++; $display("FAIL proto_w: got %h want 01fffffe", bus.rsp_w); end
      n_tests++; if (bus.rsp_l !== 24'd24) begin n_fail++; $display("FAIL proto_l: got %0d want 24", bus.rsp_l); end
      n_tests++; if (proto_err != e0) begin n_fail++; $display("FAIL proto_rules: violations=%0d want 0", proto_err - e0); end
      n_tests++; if (n_strobes - s0 != 7) begin n_fail++; $display("FAIL proto_strobes: got %0d want 7", n_strobes - s0); end
      accept();
      ready_delay = 0;
   endtask

   task automatic test_timeout();
      int lat, rb, nctrl, nwl;
      never_ready = 1'b1;
      rb = rd_addr_q.size();
      send(24'd3, 24'd5);
      wait_rsp(lat);
      nctrl = 0; nwl = 0;
      for (int i = rb; i < rd_addr_q.size(); i++) begin
         if (rd_addr_q[i] == 16'h03A0) nctrl++;
         if (rd_addr_q[i] == 16'h0390 || rd_addr_q[i] == 16'h0398) nwl++;
      end
      n_tests++; if (lat != 28) begin n_fail++; $display("FAIL to_latency: got %0d want 28", lat); end
      n_tests++; if (nctrl != 4) begin n_fail++; $display("FAIL to_polls: got %0d want 4", nctrl); end
      n_tests++; if (nwl != 0) begin n_fail++; $display("FAIL to_data_reads: got %0d want 0", nwl); end
      n_tests++; if ({bus.rsp_timeout, bus.rsp_mismatch} !== 2'b10) begin n_fail++; $display("FAIL to_flags: to/mm=%b want 10", {bus.rsp_timeout, bus.rsp_mismatch}); end
      n_tests++; if ({bus.rsp_w, bus.rsp_l} !== 56'h0) begin n_fail++; $display("FAIL to_data: w=%h l=%h want 0", bus.rsp_w, bus.rsp_l); end
      accept();
      never_ready = 1'b0;
   endtask

   task automatic test_mismatch();
      int lat;
      l_override = 1'b1; l_value = 24'd7;
      send(24'd3, 24'd5);
      wait_rsp(lat);
      n_tests++; if (bus.rsp_w !== 32'd15) begin n_fail++; $display("FAIL mm_w: got %0d want 15", bus.rsp_w); end
      n_tests++; if (bus.rsp_l !== 24'd7) begin n_fail++; $display("FAIL mm_l: got %0d want 7", bus.rsp_l); end
      n_tests++; if ({bus.rsp_timeout, bus.rsp_mismatch} !== 2'b01) begin n_fail++; $display("FAIL mm_flags: to/mm=%b want 01", {bus.rsp_timeout, bus.rsp_mismatch}); end
      accept();
      l_override = 1'b0;
   endtask

   task automatic test_back_to_back();
      int lat, wb;
      wb = wr_addr_q.size();
      send(24'd10, 24'd20);
      wait_rsp(lat);
      bus.req_a1 = 24'd7; bus.req_a2 = 24'd9; bus.req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_tests++; if ({bus.rsp_valid, bus.req_ready, bus.rsp_w, bus.rsp_l} !== {2'b10, 32'd200, 24'd3}) begin n_fail++; $display("FAIL bp_hold%0d: v=%b rdy=%b w=%0d l=%0d want 1 0 200 3", i, bus.rsp_valid, bus.req_ready, bus.rsp_w, bus.rsp_l); end
      end
      n_tests++; if (wr_addr_q.size() - wb != 3) begin n_fail++; $display("FAIL bp_ignored: writes=%0d want 3", wr_addr_q.size() - wb); end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_tests++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_accept: valid/ready=%b want 01", {bus.rsp_valid, bus.req_ready}); end
      @(posedge clk); #1 bus.req_valid = 1'b0;
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start: busy=%b want 1", bus.busy); end
      wait_rsp(lat);
      n_tests++; if (lat != 24) begin n_fail++; $display("FAIL b2b_latency: got %0d want 24", lat); end
      n_tests++; if ({bus.rsp_w, bus.rsp_l} !== {32'd63, 24'd6}) begin n_fail++; $display("FAIL b2b_data: w=%0d l=%0d want 63 6", bus.rsp_w, bus.rsp_l); end
      @(posedge clk); #1;
      n_tests++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_first_cycle_accept: valid/ready=%b want 01", {bus.rsp_valid, bus.req_ready}); end
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat, n;
      send(24'h11, 24'h22);
      n = 0;
      while (!(bus.swr === 1'b1 && bus.saddress === 16'h0388) && n < 100) begin
         @(posedge clk); #1 n++;
      end
      n_tests++; if (n >= 100) begin n_fail++; $display("FAIL rst_find_strobe: no WR_A2 strobe within %0d cycles", n); end
      #2 n_reset = 1'b0;
      #1;
      n_tests++; if ({bus.swr, bus.busy, bus.saddress} !== 18'h0) begin n_fail++; $display("FAIL rst_async: swr=%b busy=%b addr=%h want 0", bus.swr, bus.busy, bus.saddress); end
      @(negedge clk); @(negedge clk) n_reset = 1'b1;
      send(24'h100, 24'd3);
      wait_rsp(lat);
      n_tests++; if (lat != 24) begin n_fail++; $display("FAIL rst_latency: got %0d want 24", lat); end
      n_tests++; if ({bus.rsp_w, bus.rsp_l, bus.rsp_timeout, bus.rsp_mismatch} !== {32'h300, 24'd2, 2'b00}) begin n_fail++; $display("FAIL rst_data: w=%h l=%0d to=%b mm=%b want 300 2 0 0", bus.rsp_w, bus.rsp_l, bus.rsp_timeout, bus.rsp_mismatch); end
      accept();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_protocol();
      test_timeout();
      test_mismatch();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
